// File: rtl/surf_cmd_pkg.sv
// Shared definitions for the TURF->SURF serial command link.
// Used by both the SURF-side receiver and the TURF-side transmitter.
package surf_cmd_pkg;

  localparam int CMD_BUF_W      = 2;
  localparam int CMD_EVT_W      = 32;
  localparam int CMD_DATA_BITS  = 34;
  localparam int CMD_FRAME_BITS = 36;

  // Receiver FSM encoding
  localparam logic [1:0] ST_DISARM = 2'd0;
  localparam logic [1:0] ST_IDLE   = 2'd1;
  localparam logic [1:0] ST_DATA   = 2'd2;
  localparam logic [1:0] ST_STOP   = 2'd3;

  // Event IDs increase by one per command, wrapping at 32 bits
  function automatic logic [CMD_EVT_W-1:0] next_event_id(input logic [CMD_EVT_W-1:0] id);
    return id + 32'd1;
  endfunction

endpackage

// File: rtl/surf_cmd_deser.sv
// Input retiming stages, 34-bit LSB-first shift register and bit counter
// for the SURF command receiver. The first input stage is meant to be
// packed into the IOB flop.
module surf_cmd_deser
  import surf_cmd_pkg::*;
#(
  parameter int INPUT_STAGES = 1
) (
  input  logic                     clk_i,
  input  logic                     rst_n_i,
  input  logic                     cmd_i,
  input  logic                     shift_en,
  input  logic                     bit_clr,
  output logic                     line,
  output logic [CMD_DATA_BITS-1:0] data,
  output logic [5:0]               bit_cnt
);

  logic [INPUT_STAGES-1:0] stage;

  // Retime the raw command line through INPUT_STAGES flops
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      stage <= {INPUT_STAGES{1'b0}};
    end else begin
      stage[0] <= cmd_i;
      for (int i = 1; i < INPUT_STAGES; i++) begin
        stage[i] <= stage[i-1];
      end
    end
  end

  assign line = stage[INPUT_STAGES-1];

  // Shift data in LSB-first: the first received bit ends up in data[0]
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      data <= {CMD_DATA_BITS{1'b0}};
    end else if (bit_clr) begin
      data <= {CMD_DATA_BITS{1'b0}};
    end else if (shift_en) begin
      data <= {line, data[CMD_DATA_BITS-1:1]};
    end else begin
      data <= data;
    end
  end

  // Count data bits received in the current frame
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      bit_cnt <= 6'd0;
    end else if (bit_clr) begin
      bit_cnt <= 6'd0;
    end else if (shift_en) begin
      bit_cnt <= bit_cnt + 6'd1;
    end else begin
      bit_cnt <= bit_cnt;
    end
  end

endmodule

// File: rtl/surf_cmd_receiver.sv
// SURF-side deserializer for the TURF->SURF serial command line.
// Frame: start(1), buffer[1:0], event_id[31:0] LSB-first, stop(0); idle 0.
// Optional feature: define CMD_RX_SEQ_CHECK_EN to flag event IDs that are
// not the previous good ID + 1 on seq_err_o.
module surf_cmd_receiver
  import surf_cmd_pkg::*;
#(
  parameter int INPUT_STAGES = 1,
  parameter int ARM_IDLE     = 36
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  logic                 cmd_i,
  output logic [CMD_EVT_W-1:0] event_id_o,
  output logic [CMD_BUF_W-1:0] buffer_o,
  output logic                 valid_o,
  input  logic                 ready_i,
  output logic                 busy_o,
  output logic                 frame_err_o,
  output logic                 overrun_o,
  output logic                 seq_err_o
);

  localparam int ARM_W = (ARM_IDLE > 1) ? $clog2(ARM_IDLE) : 1;

  logic [1:0]               state;
  logic [1:0]               state_nxt;
  logic [ARM_W-1:0]         arm_cnt;
  logic [ARM_W-1:0]         arm_nxt;
  logic                     line;
  logic [CMD_DATA_BITS-1:0] data;
  logic [5:0]               bit_cnt;
  logic                     shift_en;
  logic                     bit_clr;
  logic                     commit_good;
  logic                     stop_bad;
  logic                     load;
  logic [CMD_EVT_W-1:0]     rx_id;
  logic [CMD_BUF_W-1:0]     rx_buf;

  surf_cmd_deser #(
    .INPUT_STAGES(INPUT_STAGES)
  ) u_deser (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .cmd_i   (cmd_i),
    .shift_en(shift_en),
    .bit_clr (bit_clr),
    .line    (line),
    .data    (data),
    .bit_cnt (bit_cnt)
  );

  assign rx_buf = data[CMD_BUF_W-1:0];
  assign rx_id  = data[CMD_DATA_BITS-1:CMD_BUF_W];

  // A good frame is taken only if the holding register is free or being emptied now
  assign load = commit_good && (!valid_o || ready_i);

  // Next-state logic: arming, start detection, data collection, stop check
  always_comb begin
    state_nxt   = state;
    arm_nxt     = arm_cnt;
    shift_en    = 1'b0;
    bit_clr     = 1'b0;
    commit_good = 1'b0;
    stop_bad    = 1'b0;
    case (state)
      ST_DISARM: begin
        if (line) begin
          arm_nxt = ARM_W'(0);
        end else if (arm_cnt == ARM_W'(ARM_IDLE - 1)) begin
          arm_nxt   = ARM_W'(0);
          state_nxt = ST_IDLE;
        end else begin
          arm_nxt = arm_cnt + ARM_W'(1);
        end
      end
      ST_IDLE: begin
        if (line) begin
          bit_clr   = 1'b1;
          state_nxt = ST_DATA;
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      ST_DATA: begin
        shift_en = 1'b1;
        if (bit_cnt == 6'(CMD_DATA_BITS - 1)) begin
          state_nxt = ST_STOP;
        end else begin
          state_nxt = ST_DATA;
        end
      end
      ST_STOP: begin
        if (line) begin
          // A 1 in the stop slot means we lost alignment; re-arm on idle
          stop_bad  = 1'b1;
          state_nxt = ST_DISARM;
        end else begin
          commit_good = 1'b1;
          state_nxt   = ST_IDLE;
        end
      end
      default: begin
        state_nxt = ST_DISARM;
        arm_nxt   = ARM_W'(0);
      end
    endcase
  end

  // FSM state, arm counter and busy flag
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state   <= ST_DISARM;
      arm_cnt <= ARM_W'(0);
      busy_o  <= 1'b0;
    end else begin
      state   <= state_nxt;
      arm_cnt <= arm_nxt;
      busy_o  <= (state_nxt == ST_DATA) || (state_nxt == ST_STOP);
    end
  end

  // Output holding register with valid/ready handshake
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      event_id_o <= {CMD_EVT_W{1'b0}};
      buffer_o   <= {CMD_BUF_W{1'b0}};
      valid_o    <= 1'b0;
    end else if (load) begin
      event_id_o <= rx_id;
      buffer_o   <= rx_buf;
      valid_o    <= 1'b1;
    end else if (valid_o && ready_i) begin
      valid_o <= 1'b0;
    end else begin
      valid_o <= valid_o;
    end
  end

  // Framing and overrun status pulses
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      frame_err_o <= 1'b0;
      overrun_o   <= 1'b0;
    end else begin
      frame_err_o <= stop_bad;
      overrun_o   <= commit_good && valid_o && !ready_i;
    end
  end

`ifdef CMD_RX_SEQ_CHECK_EN
  logic [CMD_EVT_W-1:0] last_id;
  logic                 have_last;

  // Track the last good ID (even if dropped by overrun) and flag gaps
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      last_id   <= {CMD_EVT_W{1'b0}};
      have_last <= 1'b0;
      seq_err_o <= 1'b0;
    end else if (commit_good) begin
      last_id   <= rx_id;
      have_last <= 1'b1;
      seq_err_o <= have_last && (rx_id != next_event_id(last_id));
    end else begin
      seq_err_o <= 1'b0;
    end
  end
`else
  assign seq_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_surf_cmd_receiver.sv
// Scoreboard bench for surf_cmd_receiver (default parameters).
module tb_surf_cmd_receiver;

  logic        clk_i = 1'b0;
  logic        rst_n_i = 1'b0;
  logic        cmd_i = 1'b0;
  logic        ready_i = 1'b0;
  logic [31:0] event_id_o;
  logic [1:0]  buffer_o;
  logic        valid_o;
  logic        busy_o;
  logic        frame_err_o;
  logic        overrun_o;
  logic        seq_err_o;

  surf_cmd_receiver dut (
    .clk_i      (clk_i),
    .rst_n_i    (rst_n_i),
    .cmd_i      (cmd_i),
    .event_id_o (event_id_o),
    .buffer_o   (buffer_o),
    .valid_o    (valid_o),
    .ready_i    (ready_i),
    .busy_o     (busy_o),
    .frame_err_o(frame_err_o),
    .overrun_o  (overrun_o),
    .seq_err_o  (seq_err_o)
  );

  always #5 clk_i = ~clk_i;

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [33:0] sb[$];
  int          rise_q[$];
  int          n_ferr = 0, n_ovr = 0, n_seq = 0;
  int          exp_ferr = 0, exp_ovr = 0, exp_seq = 0;
  logic [31:0] seq_id = 32'd0;
  logic [31:0] model_last = 32'd0;
  logic        model_have = 1'b0;
  int          last_start = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [35:0] frame_bits(input logic [31:0] evt, input logic [1:0] bf,
                                             input logic stop);
    return {stop, evt, bf, 1'b1};
  endfunction

  // Reference model for a frame that will complete with a good stop bit
  task automatic model_good(input logic [31:0] evt, input logic [1:0] bf, input logic push);
    if (push) sb.push_back({evt, bf});
`ifdef CMD_RX_SEQ_CHECK_EN
    if (model_have && (evt != model_last + 32'd1)) exp_seq++;
`endif
    model_last = evt;
    model_have = 1'b1;
  endtask

  task automatic send(input logic [31:0] evt, input logic [1:0] bf, input logic stop);
    logic [35:0] bits;
    bits = frame_bits(evt, bf, stop);
    last_start = cyc;
    for (int i = 0; i < 36; i++) begin
      cmd_i = bits[i];
      @(posedge clk_i); #1;
    end
    cmd_i = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk_i); #1;
    end
  endtask

  task automatic drain(input string name);
    int k;
    k = 0;
    while (sb.size() != 0 && k < 200) begin
      @(posedge clk_i); #1;
      k++;
    end
    check(name, 64'(sb.size()), 64'd0);
  endtask

  task automatic check_pulses(input string name);
    check({name, "_frame_err"}, 64'(n_ferr), 64'(exp_ferr));
    check({name, "_overrun"},   64'(n_ovr),  64'(exp_ovr));
    check({name, "_seq_err"},   64'(n_seq),  64'(exp_seq));
    n_ferr = 0; n_ovr = 0; n_seq = 0;
    exp_ferr = 0; exp_ovr = 0; exp_seq = 0;
  endtask

  // Monitor: pops the scoreboard on every accepted command, counts pulses
  task automatic monitor();
    logic        pv, pr, prst;
    logic [31:0] pe;
    logic [1:0]  pb;
    logic [33:0] e;
    pv = 1'b0; pr = 1'b0; prst = 1'b0; pe = 32'd0; pb = 2'd0;
    forever begin
      @(negedge clk_i);
      if (rst_n_i) begin
        if (frame_err_o) n_ferr++;
        if (overrun_o) n_ovr++;
        if (seq_err_o) begin
          n_seq++;
          seq_id = event_id_o;
        end
        if (valid_o && !pv) rise_q.push_back(cyc);
        if (prst && pv && !pr) begin
          check("hold_valid", 64'(valid_o), 64'd1);
          check("hold_event_id", 64'(event_id_o), 64'(pe));
          check("hold_buffer", 64'(buffer_o), 64'(pb));
        end
        if (valid_o && ready_i) begin
          if (sb.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_cmd: got id %0h buf %0h, expected none", event_id_o, buffer_o);
          end else begin
            e = sb.pop_front();
            check("sb_event_id", 64'(event_id_o), 64'(e[33:2]));
            check("sb_buffer", 64'(buffer_o), 64'(e[1:0]));
          end
        end
      end
      pv = valid_o; pr = ready_i; prst = rst_n_i; pe = event_id_o; pb = buffer_o;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected end of test");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [35:0] bits;
    fork
      monitor();
    join_none

    // Reset state
    #23;
    check("rst_valid", 64'(valid_o), 64'd0);
    check("rst_event_id", 64'(event_id_o), 64'd0);
    check("rst_buffer", 64'(buffer_o), 64'd0);
    check("rst_busy", 64'(busy_o), 64'd0);
    check("rst_pulses", 64'({frame_err_o, overrun_o, seq_err_o}), 64'd0);
    @(posedge clk_i); #1;
    rst_n_i = 1'b1;

    // Arming and single-frame latency
    idle(40);
    ready_i = 1'b1;
    rise_q.delete();
    model_good(32'h12345678, 2'b10, 1'b1);
    send(32'h12345678, 2'b10, 1'b0);
    idle(3);
    check("arm_rise_count", 64'(rise_q.size()), 64'd1);
    if (rise_q.size() >= 1) check("arm_latency", 64'(rise_q[0] - last_start), 64'd37);
    check("arm_valid_one_cycle", 64'(valid_o), 64'd0);
    drain("arm_drain");
    check_pulses("arm");

    // Back-to-back frames
    rise_q.delete();
    model_good(32'd5, 2'b00, 1'b1);
    model_good(32'd6, 2'b01, 1'b1);
    model_good(32'd7, 2'b11, 1'b1);
    send(32'd5, 2'b00, 1'b0);
    send(32'd6, 2'b01, 1'b0);
    send(32'd7, 2'b11, 1'b0);
    idle(4);
    check("b2b_rise_count", 64'(rise_q.size()), 64'd3);
    if (rise_q.size() >= 3) begin
      check("b2b_gap1", 64'(rise_q[1] - rise_q[0]), 64'd36);
      check("b2b_gap2", 64'(rise_q[2] - rise_q[1]), 64'd36);
    end
    drain("b2b_drain");
    check_pulses("b2b");

    // Overrun: second frame dropped while first is held
    ready_i = 1'b0;
    model_good(32'd10, 2'b01, 1'b1);
    model_good(32'd11, 2'b10, 1'b0);
    exp_ovr = 1;
    send(32'd10, 2'b01, 1'b0);
    send(32'd11, 2'b10, 1'b0);
    idle(5);
    check("ovr_valid_held", 64'(valid_o), 64'd1);
    check("ovr_event_id_held", 64'(event_id_o), 64'd10);
    ready_i = 1'b1;
    @(negedge clk_i);
    @(negedge clk_i);
    check("ovr_valid_cleared", 64'(valid_o), 64'd0);
    drain("ovr_drain");
    check_pulses("ovr");

    // Framing error, ignored follower, re-arm after idle
    #1;
    exp_ferr = 1;
    send(32'd20, 2'b01, 1'b1);
    send(32'd21, 2'b10, 1'b0);
    idle(40);
    check("ferr_no_valid", 64'(valid_o), 64'd0);
    model_good(32'd22, 2'b11, 1'b1);
    send(32'd22, 2'b11, 1'b0);
    idle(4);
    drain("ferr_drain");
    check_pulses("ferr");

    // Reset in the middle of a frame
    ready_i = 1'b0;
    model_good(32'd30, 2'b10, 1'b1);
    send(32'd30, 2'b10, 1'b0);
    idle(2);
    check("rmid_valid_before", 64'(valid_o), 64'd1);
    bits = frame_bits(32'hF0F0F0F0, 2'b11, 1'b0);
    for (int i = 0; i < 36; i++) begin
      cmd_i = bits[i];
      if (i == 21) begin
        check("rmid_busy_before", 64'(busy_o), 64'd1);
        rst_n_i = 1'b0;
        #1;
        check("rmid_valid", 64'(valid_o), 64'd0);
        check("rmid_event_id", 64'(event_id_o), 64'd0);
        check("rmid_buffer", 64'(buffer_o), 64'd0);
        check("rmid_busy", 64'(busy_o), 64'd0);
        check("rmid_pulses", 64'({frame_err_o, overrun_o, seq_err_o}), 64'd0);
        sb.delete();
        model_have = 1'b0;
        ready_i = 1'b1;
      end
      if (i == 24) rst_n_i = 1'b1;
      @(posedge clk_i); #1;
    end
    cmd_i = 1'b0;
    idle(50);
    check("rmid_no_valid", 64'(valid_o), 64'd0);
    check_pulses("rmid");

    // Sequence check across the 32-bit wrap
    model_good(32'hFFFFFFFF, 2'b00, 1'b1);
    model_good(32'h00000000, 2'b01, 1'b1);
    model_good(32'h00000005, 2'b10, 1'b1);
    send(32'hFFFFFFFF, 2'b00, 1'b0);
    send(32'h00000000, 2'b01, 1'b0);
    send(32'h00000005, 2'b10, 1'b0);
    idle(4);
    drain("seq_drain");
`ifdef CMD_RX_SEQ_CHECK_EN
    check("seq_err_id", 64'(seq_id), 64'h5);
`endif
    check_pulses("seq");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
